axi_lite_regbank: RTL and testbench
===================================

# axi_lite_regbank

Parametrised AXI4-Lite slave register bank for peripheral IP. It generalises the fixed four-register slave to NUM_REGS registers with byte-lane write strobes, read-only status registers, SLVERR on illegal accesses and per-register write pulses. It sits between the block-design AXI interconnect and the peripheral core, such as the VGA character-ROM controller, which consumes `reg_out` and supplies `status_in`.

## Interface
- C_S_AXI_DATA_WIDTH, 32, data width (32 or 64); byte lanes = DW/8
- C_S_AXI_ADDR_WIDTH, 6, byte address width; must satisfy 2^(AW-log2(DW/8)) >= NUM_REGS
- NUM_REGS, 8, number of word registers (1..64)
- RO_MASK, 0, NUM_REGS-bit mask; bit i = 1 makes register i read-only (reads `status_in` slice i)
- ACLK  in  1  clock; all logic rising-edge
- ARESETN  in  1  reset, asynchronous, active-low
- S_AXI_AWADDR  in  AW  write address; S_AXI_AWPROT in 3, ignored
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1  write address handshake
- S_AXI_WDATA  in  DW; S_AXI_WSTRB in DW/8; S_AXI_WVALID in 1 / S_AXI_WREADY out 1
- S_AXI_BRESP  out  2; S_AXI_BVALID out 1 / S_AXI_BREADY in 1
- S_AXI_ARADDR  in  AW; S_AXI_ARPROT in 3, ignored; S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1
- S_AXI_RDATA  out  DW; S_AXI_RRESP out 2; S_AXI_RVALID out 1 / S_AXI_RREADY in 1
- reg_out  out  NUM_REGS*DW  register contents, register i at [i*DW +: DW]
- status_in  in  NUM_REGS*DW  read-only source values, same packing; slices of RW registers are unused
- wr_pulse  out  NUM_REGS  one-cycle strobe; bit i marks a committed write to register i

## Operation
- Word index = ADDR[AW-1 : log2(DW/8)]; low address bits are ignored.
- Write channel:
  - AW and W are accepted independently, in either order, and latched in aw_held/w_held.
  - AWREADY = rst_done & !aw_held & !BVALID. WREADY = rst_done & !w_held & !BVALID.
  - One write is outstanding at a time.
- Commit on the edge where aw_held & w_held & !BVALID:
  - If index < NUM_REGS and RO_MASK[index] = 0, each byte lane b with WSTRB[b] = 1 is updated. Set wr_pulse[index] = 1 and BRESP = OKAY.
  - If index >= NUM_REGS or the register is RO, no state change, wr_pulse stays 0, BRESP = SLVERR (2'b10).
  - On the same edge: BVALID <= 1, aw_held/w_held <= 0.
  - WSTRB = 0 on an RW register: OKAY, no data change, wr_pulse still fires.
- BVALID holds with BRESP stable until BREADY; it clears on the BVALID & BREADY edge.
- Read channel:
  - ARREADY = rst_done & !RVALID.
  - On the AR handshake edge: RVALID <= 1 and RDATA/RRESP are registered.
  - RW register: current register value, OKAY.
  - RO register: `status_in` slice sampled on that edge, OKAY.
  - Out of range: RDATA = 0, SLVERR.
  - RDATA/RRESP hold until the RVALID & RREADY edge.
- Read and write channels are independent. A read handshake on the same edge as a commit to the same register returns the pre-write value.

## Timing
- Reset (ARESETN low, asynchronous):
  - All registers, reg_out, wr_pulse, BVALID, RVALID, RDATA, BRESP, RRESP, aw_held, w_held and rst_done are 0.
  - All READY outputs are therefore 0.
- rst_done sets on the first ACLK edge after deassertion, so READYs rise one cycle after release.
- Write latency: BVALID is asserted 1 cycle after the later of the AW/W handshakes (back-to-back handshakes give BVALID on the next edge).
  - reg_out changes and wr_pulse asserts on that same edge.
  - wr_pulse is high for exactly 1 cycle.
- Read latency: RVALID 1 cycle after the AR handshake. Maximum throughput is one read per 2 cycles with RREADY tied high.
- Write throughput with BREADY high: AW+W handshake, commit/BVALID, B handshake → next AW accepted on the cycle after BVALID clears.
- Reset mid-transaction discards held AW/W and pending B/R; registers return to 0.
- No combinational path from any input to any output; all outputs are driven by flops or flop-only logic.

## Test plan
- Sequential RW, NUM_REGS=8, DW=32:
  - Write 0x00000001..0x00000008 to byte addresses 0x00..0x1C, then read back → each RDATA matches, all BRESP/RRESP = OKAY.
  - wr_pulse[i] seen exactly once per write.
- Strobes: write 0xFFFFFFFF to reg 2, then write 0x11223344 with WSTRB = 4'b0101 → read 0xFF22FF44, OKAY.
- Channel order and backpressure:
  - W presented 3 cycles before AW → BVALID exactly 1 cycle after the AW handshake.
  - BREADY held low 5 cycles → BVALID/BRESP stable, AWREADY = WREADY = 0 throughout.
- Illegal access, RO_MASK = 8'h80, status_in slice 7 = 0xCAFEBABE:
  - Write reg 7 → SLVERR, reg_out unchanged, no wr_pulse.
  - Read reg 7 → 0xCAFEBABE, OKAY.
  - Read address 0x20 → RDATA 0, SLVERR.
- Collision: read reg 1 (value 0x5) on the same edge as a commit of 0x9 to reg 1 → RDATA 0x5; the following read → 0x9.
- Reset mid-operation:
  - Assert ARESETN low while aw_held = 1 and RVALID = 1 → BVALID, RVALID, READYs, reg_out all 0 immediately.
  - After release, READYs return 1 cycle later and a fresh write/read completes normally.

Source files
------------

// File: rtl/axi_lite_regbank.sv
// ---------------------------------------------------------------------------
// axi_lite_regbank
//
// Purpose:
//   AXI4-Lite slave exposing NUM_REGS word registers to a peripheral core.
//   Writes support byte-lane strobes. Registers flagged in RO_MASK are
//   read-only and return the matching status_in slice. Out-of-range or
//   read-only writes, and out-of-range reads, answer SLVERR. Every committed
//   write to a writable register raises a one-cycle wr_pulse bit.
//
// Ports:
//   ACLK, ARESETN           clock (rising edge), asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W*    write address / write data channels
//   S_AXI_B*                write response channel
//   S_AXI_AR* / S_AXI_R*    read address / read data channels
//   reg_out                 register contents, register i at [i*DW +: DW]
//   status_in               read-only sources, same packing as reg_out
//   wr_pulse                bit i strobes for one cycle on a write to reg i
//
// All outputs come straight from flops or from logic over flops only.
// ---------------------------------------------------------------------------
module axi_lite_regbank #(
  parameter int                  C_S_AXI_DATA_WIDTH = 32,
  parameter int                  C_S_AXI_ADDR_WIDTH = 6,
  parameter int                  NUM_REGS           = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK            = '0
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  // write address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  // write data channel
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  // write response channel
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  // read address channel
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  // read data channel
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  // peripheral side
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
  output logic [NUM_REGS-1:0]                    wr_pulse
);

  localparam int DW   = C_S_AXI_DATA_WIDTH;
  localparam int AW   = C_S_AXI_ADDR_WIDTH;
  localparam int NB   = DW / 8;
  localparam int LSB  = $clog2(NB);
  localparam int IDXW = AW - LSB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                rst_done_q;
  logic                aw_held_q;
  logic [IDXW-1:0]     aw_idx_q;
  logic                w_held_q;
  logic [DW-1:0]       wdata_q;
  logic [NB-1:0]       wstrb_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;
  logic                rvalid_q;
  logic [DW-1:0]       rdata_q;
  logic [1:0]          rresp_q;
  logic [NUM_REGS-1:0] wr_pulse_q;

  // -------------------------------------------------------------------------
  // Handshakes and decode
  // -------------------------------------------------------------------------
  logic                aw_hs;
  logic                w_hs;
  logic                ar_hs;
  logic                commit;
  logic [NUM_REGS-1:0] sel_w;
  logic [NUM_REGS-1:0] sel_r;
  logic [NUM_REGS-1:0] wr_en;
  logic [1:0]          bresp_d;
  logic [NUM_REGS-1:0] wr_pulse_d;
  logic [DW-1:0]       rdata_d;
  logic [1:0]          rresp_d;

  // Readies are gated by rst_done_q so nothing is accepted on the very first
  // edge after reset release. BVALID blocks both write channels, which keeps
  // at most one write in flight.
  assign S_AXI_AWREADY = rst_done_q & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = rst_done_q & ~w_held_q  & ~bvalid_q;
  assign S_AXI_ARREADY = rst_done_q & ~rvalid_q;

  assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs   = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
  assign commit = aw_held_q & w_held_q & ~bvalid_q;

  // An index beyond NUM_REGS matches no select bit, so an empty select vector
  // is exactly the out-of-range case; RO registers are masked out of wr_en.
  assign wr_en      = sel_w & ~RO_MASK;
  assign bresp_d    = (|wr_en) ? RESP_OKAY : RESP_SLVERR;
  assign wr_pulse_d = commit ? wr_en : '0;
  assign rresp_d    = (|sel_r) ? RESP_OKAY : RESP_SLVERR;

  // Read mux: RO registers return the live status slice, RW registers their
  // stored value, out-of-range reads return zero.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (sel_r[i]) begin
        rdata_d = RO_MASK[i] ? status_in[i*DW +: DW] : reg_out[i*DW +: DW];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register storage, one block per register
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DW-1:0] reg_q;

      assign sel_w[gi] = (aw_idx_q == IDXW'(gi));
      assign sel_r[gi] = (S_AXI_ARADDR[AW-1:LSB] == IDXW'(gi));

      // RO registers never see wr_en and therefore stay at zero.
      always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
          reg_q <= '0;
        end else if (commit && wr_en[gi]) begin
          for (int b = 0; b < NB; b++) begin
            if (wstrb_q[b]) begin
              reg_q[b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
          end
        end
      end

      assign reg_out[gi*DW +: DW] = reg_q;
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Write channel control
  // -------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rst_done_q <= 1'b0;
      aw_held_q  <= 1'b0;
      aw_idx_q   <= '0;
      w_held_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_pulse_q <= '0;
    end else begin
      rst_done_q <= 1'b1;
      wr_pulse_q <= wr_pulse_d;

      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= S_AXI_AWADDR[AW-1:LSB];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        wdata_q  <= S_AXI_WDATA;
        wstrb_q  <= S_AXI_WSTRB;
      end

      // A handshake cannot coincide with commit: commit needs both held
      // flags set, which holds the matching ready low.
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bvalid_q  <= 1'b1;
        bresp_q   <= bresp_d;
      end else if (bvalid_q && S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read channel control
  // -------------------------------------------------------------------------
  // rdata_d is sampled from the pre-edge register values, so a read that
  // lands on a write commit returns the old contents.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = rresp_q;
  assign wr_pulse     = wr_pulse_q;

  // Protection bits, sub-word address bits and the status slices of RW
  // registers carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0], status_in};

endmodule

// File: tb/tb_axi_lite_regbank.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regbank
//
// Directed bench for axi_lite_regbank (DW=32, AW=6, NUM_REGS=8,
// RO_MASK=8'h80). Stimulus tasks push the expected B / R responses into
// queues; a negedge monitor pops and compares on every B and R handshake.
// ---------------------------------------------------------------------------
module tb_axi_lite_regbank;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [5:0]   awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata;
  logic [255:0] reg_out, status_in;
  logic [7:0]   wr_pulse;

  always #5 clk = ~clk;

  axi_lite_regbank #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(6),
    .NUM_REGS(8),
    .RO_MASK(8'h80)
  ) dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .status_in(status_in), .wr_pulse(wr_pulse)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  int pulse_cnt[8];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: a handshake visible at negedge completes on the next posedge.
  always @(negedge clk) begin
    logic [1:0]  be;
    logic [33:0] re;
    for (int i = 0; i < 8; i++) if (wr_pulse[i]) pulse_cnt[i]++;
    if (bvalid && bready) begin
      if (bq.size() == 0) begin
        check("b_unexpected", 32'd1, 32'd0);
      end else begin
        be = bq.pop_front();
        $display("B  resp=%0d (exp %0d)", bresp, be);
        check("bresp", {30'd0, bresp}, {30'd0, be});
      end
    end
    if (rvalid && rready) begin
      if (rq.size() == 0) begin
        check("r_unexpected", 32'd1, 32'd0);
      end else begin
        re = rq.pop_front();
        $display("R  data=0x%08h resp=%0d (exp 0x%08h/%0d)", rdata, rresp, re[31:0], re[33:32]);
        check("rdata", rdata, re[31:0]);
        check("rresp", {30'd0, rresp}, {30'd0, re[33:32]});
      end
    end
  end

  // Wait until every asserted request valid has been accepted.
  task automatic hs_wait();
    logic aw_hs, w_hs, ar_hs;
    for (int c = 0; c < 50; c++) begin
      if (!(awvalid || wvalid || arvalid)) break;
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      ar_hs = arvalid && arready;
      @(posedge clk); #1;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      if (ar_hs) arvalid = 1'b0;
    end
    if (awvalid || wvalid || arvalid) begin
      check("handshake_timeout", 32'd1, 32'd0);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    end
  endtask

  // Wait for the monitor to consume every expected response.
  task automatic drain();
    for (int c = 0; c < 50 && (bq.size() != 0 || rq.size() != 0); c++) @(posedge clk);
    if (bq.size() != 0 || rq.size() != 0) begin
      check("drain_timeout", 32'd1, 32'd0);
      bq.delete();
      rq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
    bq.push_back(r);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    hs_wait();
    drain();
  endtask

  task automatic rd(input logic [5:0] a, input logic [31:0] d, input logic [1:0] r);
    rq.push_back({r, d});
    araddr = a;
    arvalid = 1'b1;
    hs_wait();
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0;
    awvalid = 0; wvalid = 0; arvalid = 0; bready = 1; rready = 1;
    wdata = '0; wstrb = '0;
    for (int i = 0; i < 8; i++) begin
      pulse_cnt[i] = 0;
      status_in[i*32 +: 32] = (i == 7) ? 32'hCAFE_BABE : (32'hDEAD_0000 + i);
    end

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", {31'd0, awready}, 32'd0);
    check("rst_arready", {31'd0, arready}, 32'd0);
    check("rst_bvalid",  {31'd0, bvalid},  32'd0);
    check("rst_rvalid",  {31'd0, rvalid},  32'd0);
    check("rst_reg_out", {31'd0, |reg_out}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_awready_early", {31'd0, awready}, 32'd0);
    @(posedge clk); #1;
    check("rel_awready", {31'd0, awready}, 32'd1);
    check("rel_wready",  {31'd0, wready},  32'd1);
    check("rel_arready", {31'd0, arready}, 32'd1);

    // ---------------- sequential RW (regs 0..6) ----------------
    for (int i = 0; i < 7; i++) wr(6'(i*4), 32'(i+1), 4'hF, OKAY);
    for (int i = 0; i < 7; i++) check("pulse_once", 32'(pulse_cnt[i]), 32'd1);
    for (int i = 0; i < 7; i++) rd(6'(i*4), 32'(i+1), OKAY);
    for (int i = 0; i < 7; i++) check("reg_out_seq", reg_out[i*32 +: 32], 32'(i+1));

    // ---------------- illegal accesses ----------------
    wr(6'h1C, 32'h1234_5678, 4'hF, SLVERR);
    check("ro_reg_out", reg_out[224 +: 32], 32'd0);
    check("ro_no_pulse", 32'(pulse_cnt[7]), 32'd0);
    rd(6'h1C, 32'hCAFE_BABE, OKAY);
    rd(6'h20, 32'd0, SLVERR);
    rd(6'h3C, 32'd0, SLVERR);
    wr(6'h24, 32'hFFFF_FFFF, 4'hF, SLVERR);
    check("oor_reg_out0", reg_out[31:0], 32'd1);

    // ---------------- strobes ----------------
    wr(6'h08, 32'hFFFF_FFFF, 4'hF, OKAY);
    wr(6'h08, 32'h1122_3344, 4'b0101, OKAY);
    rd(6'h08, 32'hFF22_FF44, OKAY);
    wr(6'h08, 32'h0000_0000, 4'b0000, OKAY);
    rd(6'h0B, 32'hFF22_FF44, OKAY);
    check("strb0_pulse", 32'(pulse_cnt[2]), 32'd4);

    // ---------------- W first, AW later, B backpressure ----------------
    bq.push_back(OKAY);
    bready = 1'b0;
    awaddr = 6'h10; wdata = 32'h0000_0077; wstrb = 4'hF;
    wvalid = 1'b1;
    @(negedge clk);
    check("w_first_ready", {31'd0, wready}, 32'd1);
    @(posedge clk); #1;
    wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("w_only_bvalid", {31'd0, bvalid}, 32'd0);
    awvalid = 1'b1;
    @(negedge clk);
    check("aw_late_ready", {31'd0, awready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(negedge clk);
    check("bvalid_early", {31'd0, bvalid}, 32'd0);
    @(negedge clk);
    check("bvalid_latency", {31'd0, bvalid}, 32'd1);
    check("commit_pulse", {24'd0, wr_pulse}, 32'h10);
    check("commit_reg_out", reg_out[128 +: 32], 32'h77);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_bvalid", {31'd0, bvalid}, 32'd1);
      check("bp_bresp", {30'd0, bresp}, 32'd0);
      check("bp_awready", {31'd0, awready}, 32'd0);
      check("bp_wready", {31'd0, wready}, 32'd0);
      if (c == 0) check("pulse_width", {24'd0, wr_pulse}, 32'd0);
    end
    @(posedge clk); #1;
    bready = 1'b1;
    drain();
    check("bp_pulse_cnt", 32'(pulse_cnt[4]), 32'd2);

    // ---------------- read/commit collision ----------------
    wr(6'h04, 32'h5, 4'hF, OKAY);
    bq.push_back(OKAY);
    rq.push_back({OKAY, 32'h5});
    awaddr = 6'h04; wdata = 32'h9; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    check("col_aw_w_ready", {31'd0, awready & wready}, 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = 6'h04; arvalid = 1'b1;
    @(negedge clk);
    check("col_arready", {31'd0, arready}, 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("col_same_edge", {30'd0, bvalid, rvalid}, 32'd3);
    drain();
    rd(6'h04, 32'h9, OKAY);

    // ---------------- reset mid-operation ----------------
    rready = 1'b0;
    awaddr = 6'h0C; awvalid = 1'b1;
    araddr = 6'h00; arvalid = 1'b1;
    @(negedge clk);
    check("mid_hs_ready", {30'd0, awready, arready}, 32'd3);
    @(posedge clk); #1;
    awvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    check("mid_pre_rvalid", {31'd0, rvalid}, 32'd1);
    check("mid_pre_awready", {31'd0, awready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_bvalid", {31'd0, bvalid}, 32'd0);
    check("mid_rvalid", {31'd0, rvalid}, 32'd0);
    check("mid_readies", {29'd0, awready, wready, arready}, 32'd0);
    check("mid_reg_out", {31'd0, |reg_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rready = 1'b1;
    @(negedge clk);
    check("mid_rel_early", {29'd0, awready, wready, arready}, 32'd0);
    @(posedge clk); #1;
    check("mid_rel_readies", {29'd0, awready, wready, arready}, 32'd7);
    rd(6'h04, 32'd0, OKAY);
    wr(6'h0C, 32'hA5A5_A5A5, 4'hF, OKAY);
    rd(6'h0C, 32'hA5A5_A5A5, OKAY);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
